// File: rtl/reflet_mem_seq.sv
// reflet_mem_seq: handshaked req/ack memory sequencer between the reflet core and RAM
// Fetches 8-bit instructions and performs lane-aligned byte/half/word/double loads and stores.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   fetch_addr, fetch_en            program counter and fetch request
//   req_valid, req_write, req_size  data access request, store flag, log2 access bytes
//   req_addr, req_wdata             data byte address, right-aligned store data
//   instruction, inst_valid         last fetched instruction and its valid flag
//   rdata, done, busy, error        load result, completion pulse, not-READY, sticky error
//   ram_addr, ram_wdata, ram_wmask  lane-aligned address, lane-shifted data, byte enables
//   ram_rdata, ram_req, ram_we      RAM read data, request, write strobe
//   ram_ack                         RAM completes the request this cycle
// Optional: define REFLET_MEM_TIMEOUT_EN to abort RAM waits after max_wait cycles.
module reflet_mem_seq #(
  parameter int wordsize = 16,
  parameter int max_wait = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [wordsize-1:0]   fetch_addr,
  input  logic                  fetch_en,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic [wordsize-1:0]   req_addr,
  input  logic [wordsize-1:0]   req_wdata,
  output logic [7:0]            instruction,
  output logic                  inst_valid,
  output logic [wordsize-1:0]   rdata,
  output logic                  done,
  output logic                  busy,
  output logic                  error,
  output logic [wordsize-1:0]   ram_addr,
  output logic [wordsize-1:0]   ram_wdata,
  output logic [wordsize/8-1:0] ram_wmask,
  input  logic [wordsize-1:0]   ram_rdata,
  output logic                  ram_req,
  output logic                  ram_we,
  input  logic                  ram_ack
);
  localparam int lanes = wordsize / 8;
  localparam int lb = $clog2(lanes);
  localparam int lbw = lb > 0 ? lb : 1;
  typedef enum logic [2:0] {FETCH_ISSUE, FETCH_WAIT, READY, DATA_ISSUE, DATA_WAIT} state_t;
  state_t state, state_n;
  logic pending;
  logic [lbw-1:0] foff_q, off_q;
  logic [wordsize-1:0] dmask_q;
  logic [3:0] nbytes;
  logic wide, misal, ack, tmo, fin;
  logic [lbw-1:0] req_off, fetch_off;
  logic [wordsize-1:0] req_dmask, fetch_sh;
  logic [lanes-1:0] req_lmask;
  // an ack only counts while a request is outstanding
  assign ack = ram_ack && ram_req;
`ifdef REFLET_MEM_TIMEOUT_EN
  localparam int cw = max_wait > 0 ? $clog2(max_wait + 1) : 1;
  logic [cw-1:0] wait_cnt;
  // counter clears whenever no request is outstanding, so it starts at 0 on each issue
  always_ff @(posedge clk)
    if (reset || !ram_req) wait_cnt <= '0;
    else if (!ram_ack) wait_cnt <= wait_cnt + 1'b1;
  assign tmo = ram_req && !ram_ack && (wait_cnt == cw'(max_wait - 1));
`else
  assign tmo = 1'b0;
`endif
  assign fin = ack || tmo;
  assign busy = state != READY;
  always_comb begin
    nbytes = 4'd1 << req_size;
    wide = int'(nbytes) >= lanes;
    misal = (int'(req_size) > lb) || ((req_addr[3:0] & (nbytes - 4'd1)) != 4'd0);
    req_off = req_addr[lbw-1:0] & lbw'(lanes - 1);
    fetch_off = fetch_addr[lbw-1:0] & lbw'(lanes - 1);
    req_dmask = wide ? '1 : {wordsize{1'b1}} >> (wordsize - 8 * int'(nbytes));
    req_lmask = wide ? '1 : {lanes{1'b1}} >> (lanes - int'(nbytes));
    fetch_sh = ram_rdata >> {foff_q, 3'b000};
  end
  always_ff @(posedge clk)
    if (reset) state <= FETCH_ISSUE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      FETCH_ISSUE: state_n = FETCH_WAIT;
      FETCH_WAIT:  state_n = fin ? READY : FETCH_WAIT;
      READY:       state_n = req_valid ? DATA_ISSUE : fetch_en ? FETCH_ISSUE : READY;
      DATA_ISSUE:  state_n = !misal ? DATA_WAIT : pending ? FETCH_ISSUE : READY;
      DATA_WAIT:   state_n = !fin ? DATA_WAIT : pending ? FETCH_ISSUE : READY;
      default:     state_n = FETCH_ISSUE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      instruction <= '0;
      inst_valid <= 1'b0;
      rdata <= '0;
      done <= 1'b0;
      error <= 1'b0;
      ram_req <= 1'b0;
      ram_we <= 1'b0;
      ram_wmask <= '0;
      ram_addr <= '0;
      ram_wdata <= '0;
      pending <= 1'b0;
      foff_q <= '0;
      off_q <= '0;
      dmask_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        FETCH_ISSUE: begin
          ram_addr <= fetch_addr & ~wordsize'(lanes - 1);
          foff_q <= fetch_off;
          ram_req <= 1'b1;
          ram_we <= 1'b0;
          inst_valid <= 1'b0;
        end
        FETCH_WAIT:
          if (fin) begin
            instruction <= tmo ? 8'h00 : fetch_sh[7:0];
            inst_valid <= 1'b1;
            ram_req <= 1'b0;
            error <= error | tmo;
          end
        READY:
          if (req_valid) pending <= fetch_en;
        DATA_ISSUE:
          if (misal) begin
            error <= 1'b1;
            done <= 1'b1;
            pending <= 1'b0;
          end else begin
            ram_addr <= req_addr & ~wordsize'(lanes - 1);
            ram_wmask <= req_lmask << req_off;
            ram_wdata <= (req_wdata & req_dmask) << {req_off, 3'b000};
            ram_we <= req_write;
            ram_req <= 1'b1;
            off_q <= req_off;
            dmask_q <= req_dmask;
          end
        DATA_WAIT:
          if (fin) begin
            if (!ram_we) rdata <= tmo ? '0 : (ram_rdata >> {off_q, 3'b000}) & dmask_q;
            ram_req <= 1'b0;
            ram_we <= 1'b0;
            done <= 1'b1;
            pending <= 1'b0;
            error <= error | tmo;
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_reflet_mem_seq.sv
// tb_reflet_mem_seq: scoreboard bench for reflet_mem_seq with a wait-state RAM model
module tb_reflet_mem_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [15:0] fetch_addr = '0, req_addr = '0, req_wdata = '0;
  logic fetch_en = 1'b0, req_valid = 1'b0, req_write = 1'b0;
  logic [1:0] req_size = '0;
  logic [7:0] instruction;
  logic inst_valid, done, busy, error, ram_req, ram_we, ram_ack;
  logic [15:0] rdata, ram_addr, ram_wdata, ram_rdata;
  logic [1:0] ram_wmask;
  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  int wait_n = 0;
  int cnt = 0;
  bit ack_en = 1'b1, stray = 1'b0;
  int checks = 0, passes = 0;
  typedef struct {logic [15:0] rd; logic er;} exp_t;
  exp_t sb [$];
  logic [15:0] last_rd = '0;
  logic err_exp = 1'b0;
  logic [1:0] cap_mask;
  logic [15:0] cap_wdata, cap_addr;
  logic cap_we;
  bit seen;

  reflet_mem_seq #(.wordsize(16), .max_wait(4)) dut (
    .clk(clk), .reset(reset), .fetch_addr(fetch_addr), .fetch_en(fetch_en),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .instruction(instruction),
    .inst_valid(inst_valid), .rdata(rdata), .done(done), .busy(busy), .error(error),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
    .ram_rdata(ram_rdata), .ram_req(ram_req), .ram_we(ram_we), .ram_ack(ram_ack)
  );

  assign ram_rdata = mem[ram_addr[8:1]];
  assign ram_ack = stray | (ack_en && ram_req && cnt >= wait_n);
  always @(posedge clk) begin
    cnt <= ram_req ? cnt + 1 : 0;
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else if (ram_req && ram_ack && ram_we) begin
      for (int b = 0; b < 2; b++)
        if (ram_wmask[b]) mem[ram_addr[8:1]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

  task automatic wait_ready(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) $display("FAIL %s_ready: busy=%b after 60 cycles, want 0", nm, busy);
    else passes++;
  endtask

  task automatic access(input bit wr, input logic [1:0] sz, input logic [15:0] a,
                        input logic [15:0] wd, input bit fe, input string nm, output int lat);
    bit mis;
    exp_t e, g;
    logic [15:0] m, ws;
    int bytes;
    bytes = 1 << sz;
    mis = (sz > 2'd1) || ((a & 16'((1 << sz) - 1)) != 16'd0);
    m = (sz == 2'd0) ? 16'h00FF : 16'hFFFF;
    if (mis) err_exp = 1'b1;
    else if (wr) begin
      ws = (wd & m) << (8 * int'(a[0]));
      for (int b = 0; b < 2; b++)
        if (b >= int'(a[0]) && b < int'(a[0]) + bytes) ref_mem[a[8:1]][b*8 +: 8] = ws[b*8 +: 8];
    end else last_rd = (ref_mem[a[8:1]] >> (8 * int'(a[0]))) & m;
    e.rd = last_rd;
    e.er = err_exp;
    sb.push_back(e);
    wait_ready(nm);
    req_write = wr; req_size = sz; req_addr = a; req_wdata = wd;
    req_valid = 1'b1; fetch_en = fe;
    lat = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      req_valid = 1'b0; fetch_en = 1'b0;
      if (ram_req) begin
        seen = 1'b1; cap_mask = ram_wmask; cap_wdata = ram_wdata; cap_addr = ram_addr; cap_we = ram_we;
      end
      if (done) begin lat = i; break; end
    end
    checks++;
    if (lat == 0) $display("FAIL %s_done: no done pulse within 40 cycles", nm);
    else passes++;
    g = sb.pop_front();
    checks++;
    if (rdata !== g.rd) $display("FAIL %s_rdata: got %h want %h", nm, rdata, g.rd);
    else passes++;
    checks++;
    if (error !== g.er) $display("FAIL %s_error: got %b want %b", nm, error, g.er);
    else passes++;
    checks++;
    if (seen !== !mis) $display("FAIL %s_ram_req_seen: got %b want %b", nm, seen, !mis);
    else passes++;
  endtask

  task automatic test_reset();
    int n = 0;
    logic [15:0] a = '0;
    fetch_addr = 16'h0003; wait_n = 3; ack_en = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, inst_valid, error, ram_req, ram_we, done} !== 6'b100000)
      $display("FAIL reset_flags: got busy/iv/err/req/we/done=%b want 100000",
               {busy, inst_valid, error, ram_req, ram_we, done});
    else passes++;
    checks++;
    if ({ram_wmask, rdata, instruction} !== 26'd0)
      $display("FAIL reset_regs: got wmask=%b rdata=%h inst=%h want 0", ram_wmask, rdata, instruction);
    else passes++;
    @(negedge clk);
    reset = 1'b0;
    err_exp = 1'b0; last_rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (ram_req) a = ram_addr;
      if (!busy) begin n = i; break; end
    end
    checks++;
    if (n !== 5) $display("FAIL fetch_latency: got %0d want 5", n);
    else passes++;
    checks++;
    if ({inst_valid, instruction} !== {1'b1, 8'hA5}) $display("FAIL fetch_inst: got %b/%h want 1/a5", inst_valid, instruction);
    else passes++;
    checks++;
    if (a !== 16'h0002) $display("FAIL fetch_ram_addr: got %h want 0002", a);
    else passes++;
  endtask

  task automatic test_store();
    int lat;
    wait_n = 0;
    @(negedge clk);
    access(1'b1, 2'd0, 16'h0011, 16'h00C3, 1'b0, "store_b", lat);
    checks++;
    if (lat !== 3) $display("FAIL store_latency: got %0d want 3", lat);
    else passes++;
    checks++;
    if ({cap_mask, cap_we, cap_wdata[15:8], cap_addr} !== {2'b10, 1'b1, 8'hC3, 16'h0010})
      $display("FAIL store_ram: got wmask=%b we=%b wdata=%h addr=%h want 10/1/c3xx/0010",
               cap_mask, cap_we, cap_wdata, cap_addr);
    else passes++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL store_ready: got busy=%b want 0", busy);
    else passes++;
  endtask

  task automatic test_load();
    int lat;
    wait_n = 2;
    access(1'b0, 2'd1, 16'h0020, 16'h0, 1'b0, "load_h20", lat);
    checks++;
    if (lat !== 5) $display("FAIL load_latency: got %0d want 5", lat);
    else passes++;
    access(1'b0, 2'd0, 16'h0021, 16'h0, 1'b0, "load_b21", lat);
    wait_n = 0;
    access(1'b0, 2'd1, 16'h0010, 16'h0, 1'b0, "load_h10", lat);
    access(1'b0, 2'd0, 16'h0010, 16'h0, 1'b0, "load_b10", lat);
    access(1'b1, 2'd1, 16'h0040, 16'h9876, 1'b0, "store_h40", lat);
    access(1'b0, 2'd1, 16'h0040, 16'h0, 1'b0, "load_h40", lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    wait_n = 1;
    fetch_addr = 16'h0020;
    access(1'b0, 2'd0, 16'h0021, 16'h0, 1'b1, "b2b", lat);
    checks++;
    if (busy !== 1'b1) $display("FAIL b2b_no_ready: got busy=%b want 1", busy);
    else passes++;
    wait_ready("b2b_fetch");
    checks++;
    if ({inst_valid, instruction} !== {1'b1, ref_mem[16][7:0]})
      $display("FAIL b2b_inst: got %b/%h want 1/%h", inst_valid, instruction, ref_mem[16][7:0]);
    else passes++;
  endtask

  task automatic test_fetch();
    fetch_addr = 16'h0011;
    wait_ready("fetch");
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL fetch_start: got busy=%b want 1", busy);
    else passes++;
    wait_ready("fetch_end");
    checks++;
    if (instruction !== ref_mem[8][15:8]) $display("FAIL fetch_lane1: got %h want %h", instruction, ref_mem[8][15:8]);
    else passes++;
  endtask

  task automatic test_misaligned();
    int lat;
    stray = 1'b1;
    access(1'b0, 2'd1, 16'h0021, 16'h0, 1'b0, "mis_h21", lat);
    stray = 1'b0;
    checks++;
    if (lat !== 2) $display("FAIL mis_latency: got %0d want 2", lat);
    else passes++;
    access(1'b1, 2'd2, 16'h0020, 16'hFFFF, 1'b0, "mis_word", lat);
    access(1'b0, 2'd1, 16'h0020, 16'h0, 1'b0, "sticky_load", lat);
  endtask

  task automatic test_wait_and_reset();
    int hi = 0;
    ack_en = 1'b0;
    fetch_addr = 16'h0002;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    err_exp = 1'b0;
`ifdef REFLET_MEM_TIMEOUT_EN
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (ram_req) hi++;
      if (!busy) break;
    end
    checks++;
    if (hi !== 4) $display("FAIL timeout_req_cycles: got %0d want 4", hi);
    else passes++;
    checks++;
    if ({error, inst_valid, instruction} !== {2'b11, 8'h00})
      $display("FAIL timeout_result: got err=%b iv=%b inst=%h want 1/1/00", error, inst_valid, instruction);
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
`else
    repeat (20) @(negedge clk);
    checks++;
    if ({ram_req, busy, error} !== 3'b110) $display("FAIL hang_wait: got req/busy/err=%b want 110", {ram_req, busy, error});
    else passes++;
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ram_req !== 1'b0) $display("FAIL reset_mid_wait: got ram_req=%b want 0", ram_req);
    else passes++;
    ack_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    err_exp = 1'b0;
    @(negedge clk);
    wait_ready("after_reset");
    checks++;
    if ({error, instruction} !== {1'b0, ref_mem[1][7:0]})
      $display("FAIL after_reset: got err=%b inst=%h want 0/%h", error, instruction, ref_mem[1][7:0]);
    else passes++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 16'h0303) ^ 16'h5A5A;
    ref_mem[1] = 16'hA55A;
    ref_mem[8] = 16'h1234;
    ref_mem[16] = 16'hBEEF;
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_fetch();
    test_misaligned();
    test_wait_and_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
